// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin share of one byte-serial AES core between two FIFO channels
module aes_core_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_BYTES = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  req0_empty,
    output logic                  req0_rd,
    input  logic [DATA_WIDTH-1:0] req0_din,
    input  logic                  req1_empty,
    output logic                  req1_rd,
    input  logic [DATA_WIDTH-1:0] req1_din,
    input  logic                  rsp0_full,
    output logic                  rsp0_wr,
    output logic [7:0]            rsp0_dout,
    input  logic                  rsp1_full,
    output logic                  rsp1_wr,
    output logic [7:0]            rsp1_dout,
    output logic                  core_load,
    output logic [7:0]            core_key,
    output logic [7:0]            core_din,
    input  logic [7:0]            core_dout,
    input  logic                  core_dvld,
    output logic                  core_rst,
    output logic                  grant,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int IW = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, WRITE, FLUSH} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         count;
    logic [TW-1:0]         timer;
    logic                  last_grant;
    logic [7:0]            mem [BLOCK_BYTES];
    logic [DATA_WIDTH-1:0] din;
    logic                  pop, cap, wr, last, tmo, waiting;

    assign din     = grant ? req1_din : req0_din;
    assign waiting = (state == WAIT) || (state == CAPTURE);
    assign pop     = (state == LOAD) && !(grant ? req1_empty : req0_empty);
    assign cap     = waiting && core_dvld;
    assign wr      = (state == WRITE) && !(grant ? rsp1_full : rsp0_full);
    assign last    = count == CW'(BLOCK_BYTES - 1);
    assign tmo     = waiting && !core_dvld && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (!req0_empty || !req1_empty) ? LOAD : IDLE;
            LOAD:    state_n = (pop && last) ? WAIT : LOAD;
            WAIT:    state_n = cap ? (last ? WRITE : CAPTURE) : (tmo ? FLUSH : WAIT);
            CAPTURE: state_n = (cap && last) ? WRITE : (tmo ? FLUSH : CAPTURE);
            WRITE:   state_n = (wr && last) ? IDLE : WRITE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy        = state != IDLE;
        core_rst    = state == FLUSH;
        err_timeout = state == FLUSH;
        req0_rd     = pop && !grant;
        req1_rd     = pop && grant;
    end

    always_ff @(posedge clock or posedge rst)
        if (rst) begin
            count      <= '0;
            timer      <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            core_load  <= 1'b0;
            core_key   <= 8'h0;
            core_din   <= 8'h0;
            rsp0_wr    <= 1'b0;
            rsp1_wr    <= 1'b0;
            rsp0_dout  <= 8'h0;
            rsp1_dout  <= 8'h0;
        end else begin
            core_load <= pop;
            if (pop) begin
                core_key <= din[DATA_WIDTH-1:DATA_WIDTH-8];
                core_din <= din[7:0];
            end
            rsp0_wr <= wr && !grant;
            rsp1_wr <= wr && grant;
            if (wr && !grant) rsp0_dout <= mem[count[IW-1:0]];
            if (wr && grant) rsp1_dout <= mem[count[IW-1:0]];
            case (state)
                IDLE: begin
                    if (!req0_empty || !req1_empty)
                        grant <= (!req0_empty && !req1_empty) ? ~last_grant : req0_empty;
                    count <= '0;
                    timer <= '0;
                end
                LOAD: if (pop) count <= last ? '0 : count + 1'b1;
                WAIT, CAPTURE: begin
                    if (cap) count <= last ? '0 : count + 1'b1;
                    timer <= (cap || tmo) ? '0 : timer + 1'b1;
                end
                WRITE: begin
                    if (wr) count <= last ? '0 : count + 1'b1;
                    if (wr && last) last_grant <= grant;
                end
                default: begin
                    last_grant <= grant;
                    count      <= '0;
                    timer      <= '0;
                end
            endcase
        end

    always_ff @(posedge clock)
        if (cap) mem[count[IW-1:0]] <= core_dout;
endmodule
